j_fdsync_bank: RTL and testbench



---
 rtl/j_fdsync_pkg.sv | 25 ++
 rtl/j_fdsync_chan.sv | 55 +++++
 rtl/j_fdsync_bank.sv | 70 +++++++
 tb/tb_j_fdsync_bank.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/j_fdsync_pkg.sv
// Shared helpers for the double-buffered sync register bank: size functions and the byte-lane merge.
package j_fdsync_pkg;

  localparam int MAX_W = 64;
  localparam int MAX_B = MAX_W / 8;

  function automatic int byte_cnt(input int width);
    return width / 8;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Lane i of the result comes from new_v when be[i] is set, else from old_v.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_v,
                                                  input logic [MAX_W-1:0] new_v,
                                                  input logic [MAX_B-1:0] be);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_B; i++)
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/j_fdsync_chan.sv
// One channel: shadow, active and pending flops. FDSYNC_SHADOW_RD_EN exposes the shadow value.
module j_fdsync_chan
  import j_fdsync_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [byte_cnt(WIDTH)-1:0] be,
  input  logic [WIDTH-1:0]           d,
  input  logic                       commit,
  output logic [WIDTH-1:0]           active,
  output logic                       pending,
  output logic                       hit
`ifdef FDSYNC_SHADOW_RD_EN
  , output logic [WIDTH-1:0]         shadow
`endif
);

  logic [WIDTH-1:0] shadow_r;
  logic [WIDTH-1:0] merged;
  logic [MAX_W-1:0] merged_x;
  logic             wr_en;
  logic             unused_hi;

  assign wr_en     = wr && (|be);
  assign merged_x  = byte_merge(MAX_W'(shadow_r), MAX_W'(d), MAX_B'(be));
  assign unused_hi = ^merged_x;
  // Merged value feeds both the shadow and a same-edge commit.
  assign merged    = wr_en ? merged_x[WIDTH-1:0] : shadow_r;
  assign hit       = commit && pending;

`ifdef FDSYNC_SHADOW_RD_EN
  assign shadow = shadow_r;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      shadow_r <= RESET_VAL;
      active   <= RESET_VAL;
      pending  <= 1'b0;
    end else begin
      shadow_r <= merged;
      if (hit) begin
        active  <= merged;
        pending <= 1'b0;
      end else if (wr_en) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/j_fdsync_bank.sv
// CHANNELS double-buffered registers committed atomically on sync.
// FDSYNC_SHADOW_RD_EN adds shadow_q readback of shadow[ld_chan].
module j_fdsync_bank
  import j_fdsync_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          ld,
  input  logic [idx_w(CHANNELS)-1:0]    ld_chan,
  input  logic [byte_cnt(WIDTH)-1:0]    be,
  input  logic [WIDTH-1:0]              d,
  input  logic                          sync,
  input  logic [CHANNELS-1:0]           sync_mask,
  output logic [CHANNELS*WIDTH-1:0]     q,
  output logic [CHANNELS-1:0]           pending,
  output logic                          committed
`ifdef FDSYNC_SHADOW_RD_EN
  , output logic [WIDTH-1:0]            shadow_q
`endif
);

  localparam int CW = idx_w(CHANNELS);

  logic [CHANNELS-1:0]            hit;
  logic [CHANNELS-1:0][WIDTH-1:0] active;
`ifdef FDSYNC_SHADOW_RD_EN
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_all;
`endif

  // Out-of-range ld_chan matches no channel, so such writes vanish.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    j_fdsync_chan #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_chan (
      .sys_clk (sys_clk),
      .reset   (reset),
      .wr      (ld && (ld_chan == CW'(c))),
      .be      (be),
      .d       (d),
      .commit  (sync && sync_mask[c]),
      .active  (active[c]),
      .pending (pending[c]),
      .hit     (hit[c])
`ifdef FDSYNC_SHADOW_RD_EN
      , .shadow (shadow_all[c])
`endif
    );
  end

  assign q = active;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) committed <= 1'b0;
    else       committed <= |hit;
  end

`ifdef FDSYNC_SHADOW_RD_EN
  always_comb begin
    shadow_q = RESET_VAL;
    for (int c = 0; c < CHANNELS; c++)
      if (ld_chan == CW'(c)) shadow_q = shadow_all[c];
  end
`endif

endmodule

// File: tb/tb_j_fdsync_bank.sv
// Directed + random bench for j_fdsync_bank (32x4 and 16x3 instances) against a queue-free array model.
module tb_j_fdsync_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ld_a, sync_a;
  logic [1:0]  ch_a;
  logic [3:0]  be_a, mk_a;
  logic [31:0] d_a;
  logic [127:0] q_a;
  logic [3:0]  pend_a;
  logic        comm_a;

  logic        ld_b, sync_b;
  logic [1:0]  ch_b, be_b;
  logic [15:0] d_b;
  logic [2:0]  mk_b;
  logic [47:0] q_b;
  logic [2:0]  pend_b;
  logic        comm_b;
`ifdef FDSYNC_SHADOW_RD_EN
  logic [31:0] shq_a;
  logic [15:0] shq_b;
`endif

  j_fdsync_bank #(.WIDTH(32), .CHANNELS(4), .RESET_VAL(32'h0)) u_a (
    .sys_clk(clk), .reset(rst), .ld(ld_a), .ld_chan(ch_a), .be(be_a), .d(d_a),
    .sync(sync_a), .sync_mask(mk_a), .q(q_a), .pending(pend_a), .committed(comm_a)
`ifdef FDSYNC_SHADOW_RD_EN
    , .shadow_q(shq_a)
`endif
  );

  j_fdsync_bank #(.WIDTH(16), .CHANNELS(3), .RESET_VAL(16'h0)) u_b (
    .sys_clk(clk), .reset(rst), .ld(ld_b), .ld_chan(ch_b), .be(be_b), .d(d_b),
    .sync(sync_b), .sync_mask(mk_b), .q(q_b), .pending(pend_b), .committed(comm_b)
`ifdef FDSYNC_SHADOW_RD_EN
    , .shadow_q(shq_b)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: index 0 = 32x4 instance, 1 = 16x3 instance.
  int          NW[2] = '{32, 16};
  int          NC[2] = '{4, 3};
  logic [63:0] m_sh [2][16];
  logic [63:0] m_act[2][16];
  logic [15:0] m_pend[2];
  logic        m_comm[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 16; c++) begin
        m_sh[k][c]  = 64'h0;
        m_act[k][c] = 64'h0;
      end
      m_pend[k] = 16'h0;
      m_comm[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k, input logic ld, input int ch, input logic [7:0] be,
                            input logic [63:0] d, input logic sync, input logic [15:0] mask);
    logic [15:0] cm;
    logic [63:0] m;
    cm = sync ? (mask & m_pend[k]) : 16'h0;
    if (ld && ch < NC[k] && be != 8'h0) begin
      m = 64'h0;
      for (int b = 0; b < NW[k] / 8; b++)
        if (be[b]) m = m | (64'hFF << (8 * b));
      m_sh[k][ch]   = (m_sh[k][ch] & ~m) | (d & m);
      m_pend[k][ch] = 1'b1;
    end
    for (int c = 0; c < NC[k]; c++)
      if (cm[c]) begin
        m_act[k][c]  = m_sh[k][c];
        m_pend[k][c] = 1'b0;
      end
    m_comm[k] = (cm != 16'h0);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s_qa%0d", tag, c), 64'(q_a[c*32 +: 32]), m_act[0][c]);
    chk({tag, "_pend_a"}, 64'(pend_a), 64'(m_pend[0][3:0]));
    chk({tag, "_comm_a"}, 64'(comm_a), 64'(m_comm[0]));
    for (int c = 0; c < 3; c++)
      chk($sformatf("%s_qb%0d", tag, c), 64'(q_b[c*16 +: 16]), m_act[1][c]);
    chk({tag, "_pend_b"}, 64'(pend_b), 64'(m_pend[1][2:0]));
    chk({tag, "_comm_b"}, 64'(comm_b), 64'(m_comm[1]));
`ifdef FDSYNC_SHADOW_RD_EN
    chk({tag, "_shq_a"}, 64'(shq_a), m_sh[0][ch_a]);
    chk({tag, "_shq_b"}, 64'(shq_b), (ch_b < 2'd3) ? m_sh[1][ch_b] : 64'h0);
`endif
  endtask

  task automatic idle();
    ld_a = 0; ch_a = 0; be_a = 0; d_a = 0; sync_a = 0; mk_a = 0;
    ld_b = 0; ch_b = 0; be_b = 0; d_b = 0; sync_b = 0; mk_b = 0;
  endtask

  // One clock cycle driving instance k; the other instance idles.
  task automatic cyc(input int k, input logic ld, input int ch, input logic [7:0] be_in,
                     input logic [63:0] d, input logic sync, input logic [15:0] mask_in);
    logic [7:0]  be;
    logic [15:0] mask;
    be   = be_in & 8'((1 << (NW[k] / 8)) - 1);
    mask = mask_in & 16'((1 << NC[k]) - 1);
    @(negedge clk);
    idle();
    if (k == 0) begin
      ld_a = ld; ch_a = 2'(ch); be_a = be[3:0]; d_a = d[31:0]; sync_a = sync; mk_a = mask[3:0];
    end else begin
      ld_b = ld; ch_b = 2'(ch); be_b = be[1:0]; d_b = d[15:0]; sync_b = sync; mk_b = mask[2:0];
    end
    @(posedge clk);
    model_edge(k, ld, ch, be, d, sync, mask);
    model_edge(1 - k, 1'b0, 0, 8'h0, 64'h0, 1'b0, 16'h0);
    #1;
    check_all("cyc");
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    check_all("reset");
    chk("reset_pend", 64'(pend_a), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Byte-lane write then commit.
    cyc(0, 1, 2, 8'b0101, 64'hAABBCCDD, 0, 0);
    chk("byte_pend", 64'(pend_a), 64'h4);
    chk("byte_q2_hold", 64'(q_a[95:64]), 64'h0);
    cyc(0, 0, 0, 8'h0, 64'h0, 1, 16'hF);
    chk("byte_q2", 64'(q_a[95:64]), 64'h00BB00DD);
    chk("byte_comm", 64'(comm_a), 64'h1);
    cyc(0, 0, 0, 8'h0, 64'h0, 0, 16'h0);
    chk("comm_pulse", 64'(comm_a), 64'h0);

    // Masked commit.
    cyc(0, 1, 0, 8'hF, 64'h11111111, 0, 0);
    cyc(0, 1, 1, 8'hF, 64'h22222222, 0, 0);
    cyc(0, 0, 0, 8'h0, 64'h0, 1, 16'b0001);
    chk("mask_q0", 64'(q_a[31:0]), 64'h11111111);
    chk("mask_q1_hold", 64'(q_a[63:32]), 64'h0);
    chk("mask_pend", 64'(pend_a), 64'h2);
    cyc(0, 0, 0, 8'h0, 64'h0, 1, 16'hF);
    chk("mask_q1", 64'(q_a[63:32]), 64'h22222222);

    // Same-edge write and commit uses merged value.
    cyc(0, 1, 3, 8'hF, 64'h12345678, 0, 0);
    cyc(0, 1, 3, 8'b1000, 64'hFF000000, 1, 16'b1000);
    chk("simul_q3", 64'(q_a[127:96]), 64'hFF345678);
    chk("simul_pend", 64'(pend_a), 64'h0);

    // Idle sync and be=0 write.
    cyc(0, 0, 0, 8'h0, 64'h0, 1, 16'hF);
    chk("idle_comm", 64'(comm_a), 64'h0);
    cyc(0, 1, 1, 8'b0001, 64'h9, 0, 0);
    cyc(0, 1, 0, 8'h0, 64'hDEAD, 0, 0);
    chk("be0_pend", 64'(pend_a), 64'h2);
    cyc(0, 0, 0, 8'h0, 64'h0, 1, 16'hF);

    // 16x3 instance: out-of-range channel is ignored.
    cyc(1, 1, 3, 8'b11, 64'hBEEF, 0, 0);
    chk("oor_pend", 64'(pend_b), 64'h0);
    cyc(1, 1, 2, 8'b10, 64'hA5FF, 0, 0);
    chk("b_pend", 64'(pend_b), 64'h4);
    cyc(1, 0, 0, 8'h0, 64'h0, 1, 16'h7);
    chk("b_q2", 64'(q_b[47:32]), 64'hA500);

    // Asynchronous reset with pending channels.
    cyc(0, 1, 1, 8'hF, 64'h5, 0, 0);
    cyc(0, 1, 3, 8'hF, 64'h7, 0, 0);
    chk("pre_rst_pend", 64'(pend_a), 64'hA);
    @(negedge clk);
    idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    chk("rst_mid_pend", 64'(pend_a), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
          8'($urandom), {$urandom, $urandom}, ($urandom_range(3, 0) == 0), 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
